// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: serialises 128-bit cache line write-backs and refills into 32-bit memory bus words.
// Optional CACHE_MEM_BRIDGE_CRITICAL_WORD_FIRST_EN: refill starts at the word addressed by fill_addr and wraps.
module cache_mem_bridge #(
  parameter int WORD_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_back_enable,
  input  logic [WORD_WIDTH-1:0] write_back_addr,
  input  logic [LINE_WIDTH-1:0] write_back_data,
  output logic                  write_back_finished,
  input  logic                  fill_req,
  input  logic [WORD_WIDTH-1:0] fill_addr,
  output logic [LINE_WIDTH-1:0] ldata,
  output logic                  fill_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);
  localparam int LINE_WORDS = LINE_WIDTH / WORD_WIDTH;
  localparam int CW = $clog2(LINE_WORDS);
  localparam int BS = $clog2(WORD_WIDTH / 8);
  localparam logic [WORD_WIDTH-1:0] BASE_MASK = ~WORD_WIDTH'((1 << OFFSET_BITS) - 1);
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  state_t                r_state, w_next;
  logic                  r_wb_prev, r_fill_prev, r_fill_pend, r_wb_fin;
  logic [CW-1:0]         r_cnt, w_start, w_fidx;
  logic [WORD_WIDTH-1:0] r_wb_base, r_fill_base;
  logic [LINE_WIDTH-1:0] r_wb_data, r_ldata;
  logic                  w_wb_edge, w_fill_edge, w_last, w_wb_done;
  assign w_wb_edge   = write_back_enable & ~r_wb_prev;
  assign w_fill_edge = fill_req & ~r_fill_prev;
  assign w_last      = mem_ready && (r_cnt == CW'(LINE_WORDS - 1));
  assign w_wb_done   = (r_state == WB) && w_last;
  assign w_fidx      = r_cnt + w_start;
  assign write_back_finished = r_wb_fin;
  assign ldata = r_ldata;
`ifdef CACHE_MEM_BRIDGE_CRITICAL_WORD_FIRST_EN
  logic [CW-1:0] r_start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_start <= '0;
    else if (w_fill_edge && (r_state == IDLE || r_state == WB)) r_start <= fill_addr[OFFSET_BITS-1:BS];
  assign w_start = r_start;
`else
  assign w_start = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    case (r_state)
      IDLE: w_next = w_wb_edge ? WB : w_fill_edge ? FILL : IDLE;
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_wb_base | WORD_WIDTH'({r_cnt, {BS{1'b0}}});
        mem_wdata = r_wb_data[r_cnt*WORD_WIDTH +: WORD_WIDTH];
        w_next    = !w_last ? WB : (r_fill_pend || w_fill_edge) ? FILL : IDLE;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = r_fill_base | WORD_WIDTH'({w_fidx, {BS{1'b0}}});
        w_next   = w_last ? DONE : FILL;
      end
      default: begin
        fill_valid = 1'b1;
        w_next     = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wb_prev   <= 1'b0;
      r_fill_prev <= 1'b0;
      r_fill_pend <= 1'b0;
      r_wb_fin    <= 1'b1;
      r_cnt       <= '0;
      r_wb_base   <= '0;
      r_fill_base <= '0;
      r_wb_data   <= '0;
      r_ldata     <= '0;
    end else begin
      r_wb_prev   <= write_back_enable;
      r_fill_prev <= fill_req;
      if (r_state == IDLE && w_wb_edge) begin
        r_wb_base <= write_back_addr & BASE_MASK;
        r_wb_data <= write_back_data;
        r_wb_fin  <= 1'b0;
      end
      if (w_fill_edge && (r_state == IDLE || r_state == WB)) r_fill_base <= fill_addr & BASE_MASK;
      // a fill seen together with or during a write-back waits for the write-back to finish
      if (w_wb_done) r_fill_pend <= 1'b0;
      else if (w_fill_edge && ((r_state == IDLE && w_wb_edge) || r_state == WB)) r_fill_pend <= 1'b1;
      if (w_wb_done) r_wb_fin <= 1'b1;
      if ((r_state == WB || r_state == FILL) && mem_ready) r_cnt <= r_cnt + 1'b1;
      if (r_state == FILL && mem_ready) r_ldata[w_fidx*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
    end
endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: directed checks of write-back, stall, refill, chained ops and reset for cache_mem_bridge.
module tb_cache_mem_bridge;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         write_back_enable = 1'b0;
  logic [31:0]  write_back_addr = '0;
  logic [127:0] write_back_data = '0;
  logic         write_back_finished;
  logic         fill_req = 1'b0;
  logic [31:0]  fill_addr = '0;
  logic [127:0] ldata;
  logic         fill_valid;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ready = 1'b0;
  logic [31:0]  base_val = 32'h100;
  int           n_chk = 0;
  int           n_err = 0;
  logic [31:0]  exp_a [4];

  cache_mem_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .write_back_enable(write_back_enable), .write_back_addr(write_back_addr),
    .write_back_data(write_back_data), .write_back_finished(write_back_finished),
    .fill_req(fill_req), .fill_addr(fill_addr), .ldata(ldata), .fill_valid(fill_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // memory model: one distinctive word, and a low region whose data encodes the address
  always_comb
    mem_rdata = (mem_addr == 32'hA000_0000) ? 32'h0000_AAAA :
                (mem_addr[31:8] == 24'h0) ? {24'h0, mem_addr[7:0]} + base_val : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fin", write_back_finished, 1);
    chk("rst_fv", fill_valid, 0);
    chk("rst_ldata", ldata, 0);
    tick();

    // write-back with mem_ready tied high
    write_back_addr = 32'h4000_0008;
    write_back_data = 128'h0000_1010_0000_1C1C_1414_0000_0000_1111;
    write_back_enable = 1'b1;
    mem_ready = 1'b1;
    tick();
    exp_a = '{32'h0000_1111, 32'h1414_0000, 32'h0000_1C1C, 32'h0000_1010};
    for (int i = 0; i < 4; i++) begin
      chk("wb_req", mem_req, 1);
      chk("wb_we", mem_we, 1);
      chk("wb_addr", mem_addr, 32'h4000_0000 + 4 * i);
      chk("wb_data", mem_wdata, exp_a[i]);
      chk("wb_fin_low", write_back_finished, 0);
      tick();
    end
    chk("wb_fin_high", write_back_finished, 1);
    chk("wb_end_req", mem_req, 0);
    tick();
    tick();
    chk("wb_held_no_retrig", mem_req, 0);
    chk("wb_held_fin", write_back_finished, 1);
    write_back_enable = 1'b0;
    tick();

    // write-back with a 3-cycle stall on word 1
    write_back_addr = 32'h4000_0004;
    write_back_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    write_back_enable = 1'b1;
    tick();
    chk("st_w0_addr", mem_addr, 32'h4000_0000);
    chk("st_w0_data", mem_wdata, 32'h1111_1111);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("st_hold_req", mem_req, 1);
      chk("st_hold_addr", mem_addr, 32'h4000_0004);
      chk("st_hold_data", mem_wdata, 32'h2222_2222);
      tick();
    end
    mem_ready = 1'b1;
    chk("st_w1_addr", mem_addr, 32'h4000_0004);
    tick();
    chk("st_w2_addr", mem_addr, 32'h4000_0008);
    chk("st_w2_data", mem_wdata, 32'h3333_3333);
    tick();
    chk("st_w3_addr", mem_addr, 32'h4000_000C);
    chk("st_w3_data", mem_wdata, 32'h4444_4444);
    chk("st_w3_fin", write_back_finished, 0);
    tick();
    chk("st_fin", write_back_finished, 1);
    chk("st_end_req", mem_req, 0);
    write_back_enable = 1'b0;
    tick();

    // refill of line 0xA000_0000
    fill_addr = 32'hA000_0004;
    fill_req = 1'b1;
    tick();
`ifdef CACHE_MEM_BRIDGE_CRITICAL_WORD_FIRST_EN
    exp_a = '{32'hA000_0004, 32'hA000_0008, 32'hA000_000C, 32'hA000_0000};
`else
    exp_a = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008, 32'hA000_000C};
`endif
    for (int i = 0; i < 4; i++) begin
      chk("fl_req", mem_req, 1);
      chk("fl_we", mem_we, 0);
      chk("fl_addr", mem_addr, exp_a[i]);
      chk("fl_fv_low", fill_valid, 0);
      tick();
    end
    chk("fl_fv", fill_valid, 1);
    chk("fl_ldata", ldata, 128'hAAAA);
    chk("fl_done_req", mem_req, 0);
    tick();
    chk("fl_fv_pulse", fill_valid, 0);
    chk("fl_ldata_hold", ldata, 128'hAAAA);
    tick();
    chk("fl_no_retrig", mem_req, 0);
    fill_req = 1'b0;
    tick();

    // simultaneous write-back and fill edges
    write_back_addr = 32'h0000_0028;
    write_back_data = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;
    fill_addr = 32'h0000_0010;
    write_back_enable = 1'b1;
    fill_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sim_wb_we", mem_we, 1);
      chk("sim_wb_addr", mem_addr, 32'h20 + 4 * i);
      chk("sim_wb_data", mem_wdata, 32'hDDDD_0000 + i);
      tick();
    end
    chk("sim_nobubble_req", mem_req, 1);
    chk("sim_fin_before_fv", write_back_finished, 1);
    for (int i = 0; i < 4; i++) begin
      chk("sim_fl_we", mem_we, 0);
      chk("sim_fl_addr", mem_addr, 32'h10 + 4 * i);
      chk("sim_fl_fv_low", fill_valid, 0);
      tick();
    end
    chk("sim_fv", fill_valid, 1);
    chk("sim_ldata", ldata, 128'h0000_011C_0000_0118_0000_0114_0000_0110);
    write_back_enable = 1'b0;
    fill_req = 1'b0;
    tick();

    // fill ordering from a mid-line address
    base_val = 32'h200;
    fill_addr = 32'h0000_0018;
    fill_req = 1'b1;
    tick();
`ifdef CACHE_MEM_BRIDGE_CRITICAL_WORD_FIRST_EN
    exp_a = '{32'h18, 32'h1C, 32'h10, 32'h14};
`else
    exp_a = '{32'h10, 32'h14, 32'h18, 32'h1C};
`endif
    for (int i = 0; i < 4; i++) begin
      chk("ord_addr", mem_addr, exp_a[i]);
      tick();
    end
    chk("ord_fv", fill_valid, 1);
    chk("ord_ldata", ldata, 128'h0000_021C_0000_0218_0000_0214_0000_0210);
    fill_req = 1'b0;
    tick();

    // asynchronous reset in the middle of a write-back
    write_back_addr = 32'h4000_0000;
    write_back_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    write_back_enable = 1'b1;
    tick();
    tick();
    tick();
    chk("mr_pre_req", mem_req, 1);
    chk("mr_pre_addr", mem_addr, 32'h4000_0008);
    #1;
    rst_n = 1'b0;
    write_back_enable = 1'b0;
    #1;
    chk("mr_req", mem_req, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_fin", write_back_finished, 1);
    chk("mr_addr", mem_addr, 0);
    chk("mr_wdata", mem_wdata, 0);
    chk("mr_ldata", ldata, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mr_idle_req", mem_req, 0);
    chk("mr_idle_fin", write_back_finished, 1);

    // request already high at reset release is a new edge
    rst_n = 1'b0;
    fill_req = 1'b1;
    fill_addr = 32'h0000_0010;
    tick();
    chk("rel_in_rst", mem_req, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_edge_req", mem_req, 1);
    chk("rel_edge_we", mem_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
